// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the PLL supervisor / clock-enable sequencer.
// Holds the sequencer state encoding and the per-channel divide/phase sanitising rule.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [31:0] d_eff;
    logic [31:0] p_eff;
  } ch_eff_t;

  // Width of the stability counter; floors at 1 so tiny qualification windows still build.
  function automatic int stab_cnt_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

  // A divide of 0 behaves as 1, and a phase outside the divide range falls back to 0.
  function automatic ch_eff_t channel_eff(input logic [31:0] d, input logic [31:0] p);
    ch_eff_t r;
    r.d_eff = (d == 32'd0) ? 32'd1 : d;
    r.p_eff = (p < r.d_eff) ? p : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/ce_divider_ch.sv
// One clock-enable channel: a modulo-d_eff counter that strobes on its terminal count.
// load realigns the counter to the phase; run low holds the channel idle.
module ce_divider_ch
  import clk_seq_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] d,
  input  logic [DIV_W-1:0] p,
  input  logic             en,
  output logic             ce,
  output logic [DIV_W-1:0] cnt
);

  ch_eff_t          eff;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] p_eff;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] cnt_nxt;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    eff   = channel_eff(32'(d), 32'(p));
    d_eff = DIV_W'(eff.d_eff);
    p_eff = DIV_W'(eff.p_eff);
    last  = d_eff - 1'b1;
    if (load) begin
      cnt_nxt = p_eff;
    end else if (cnt == last) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // ce is registered from the counter's next value so it lines up with that count.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ce  <= en && (cnt_nxt == last);
    end
  end

endmodule

// File: rtl/clk_enable_sequencer.sv
// PLL lock supervisor with qualification, loss handling and domain reset/ready generation,
// plus NUM_CH phase-programmable clock-enable strobes active only while running.
module clk_enable_sequencer
  import clk_seq_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DIV_W           = 8,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int LOST_CNT_W      = 8
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]       cfg_ch_en,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    domain_rst,
  output logic                    ready,
  output logic [LOST_CNT_W-1:0]   lock_lost_cnt
);

  localparam int STAB_CNT_W = stab_cnt_w(LOCK_STABLE_CYC);

  seq_state_t              state, next_state;
  logic                    sync_q1, locked_s;
  logic [STAB_CNT_W-1:0]   stab_cnt;
  logic                    stab_done;
  logic                    ch_load, ch_run, lost_inc;
  logic [NUM_CH*DIV_W-1:0] div_q, phase_q, div_mux, phase_mux;
  logic [NUM_CH-1:0]       ch_en_q, ch_en_mux;
  logic [DIV_W-1:0]        ch_cnt_unused [NUM_CH];

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
    end
  end

  assign stab_done = (stab_cnt == STAB_CNT_W'(LOCK_STABLE_CYC - 1));

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: if (locked_s) next_state = STABLE;
      STABLE: begin
        if (!locked_s)      next_state = WAIT_LOCK;
        else if (stab_done) next_state = RUN;
      end
      RUN:     if (!locked_s) next_state = LOST;
      LOST:    next_state = WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  // A lock loss pre-empts cfg_load because next_state then leaves RUN.
  always_comb begin
    ch_run   = (next_state == RUN);
    ch_load  = ch_run && ((state == STABLE) || ((state == RUN) && cfg_load));
    lost_inc = (next_state == LOST) && (lock_lost_cnt != '1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      stab_cnt      <= '0;
      ready         <= 1'b0;
      domain_rst    <= 1'b1;
      lock_lost_cnt <= '0;
    end else begin
      state         <= next_state;
      stab_cnt      <= (state == STABLE) ? stab_cnt + 1'b1 : '0;
      ready         <= ch_run;
      domain_rst    <= !ch_run;
      if (lost_inc) lock_lost_cnt <= lock_lost_cnt + 1'b1;
    end
  end

  // NOTE: the config shadow has no reset; it is always loaded on RUN entry before any channel uses it.
  always_ff @(posedge refclk) begin
    if (ch_load) begin
      div_q   <= cfg_div;
      phase_q <= cfg_phase;
      ch_en_q <= cfg_ch_en;
    end
  end

  // On a load edge the channels see the incoming config, otherwise the latched copy.
  assign div_mux   = ch_load ? cfg_div   : div_q;
  assign phase_mux = ch_load ? cfg_phase : phase_q;
  assign ch_en_mux = ch_load ? cfg_ch_en : ch_en_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ce_divider_ch #(.DIV_W(DIV_W)) u_ch (
      .clk  (refclk),
      .rst  (rst),
      .load (ch_load),
      .run  (ch_run),
      .d    (div_mux[i*DIV_W +: DIV_W]),
      .p    (phase_mux[i*DIV_W +: DIV_W]),
      .en   (ch_en_mux[i]),
      .ce   (ce_out[i]),
      .cnt  (ch_cnt_unused[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Directed bench for clk_enable_sequencer: stimulus pushes expected strobe patterns into a
// queue, and a negedge monitor pops one entry per ready cycle and compares it with ce_out.
module tb_clk_enable_sequencer;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int LSC    = 16;
  localparam int LCW    = 8;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic [NUM_CH*DIV_W-1:0] cfg_phase;
  logic [NUM_CH-1:0]       cfg_ch_en;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       ce_out;
  logic                    domain_rst;
  logic                    ready;
  logic [LCW-1:0]          lock_lost_cnt;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;
  logic [NUM_CH-1:0] exp_q[$];
  logic [NUM_CH-1:0] exp_ce;

  clk_enable_sequencer #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE_CYC(LSC), .LOST_CNT_W(LCW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .cfg_div       (cfg_div),
    .cfg_phase     (cfg_phase),
    .cfg_ch_en     (cfg_ch_en),
    .cfg_load      (cfg_load),
    .ce_out        (ce_out),
    .domain_rst    (domain_rst),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Scoreboard monitor: strobe patterns while ready, quiet outputs otherwise.
  always @(negedge refclk) begin
    if (mon_en) begin
      if (ready === 1'b1) begin
        check("domain_rst_run", 32'(domain_rst), 32'd0);
        if (exp_q.size() > 0) begin
          exp_ce = exp_q.pop_front();
          check("ce_run", 32'(ce_out), 32'(exp_ce));
        end
      end else begin
        check("ce_idle", 32'(ce_out), 32'd0);
        check("domain_rst_idle", 32'(domain_rst), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got edge %0d, expected completion", edge_n);
    $fatal(1);
  end

  // Return just after edge n; inputs driven then are sampled at edge n+1.
  task automatic after_edge(input int n);
    wait (edge_n >= n);
    #1;
  endtask

  // Land on the negedge just before edge m, where the value "at edge m" is visible.
  task automatic at_edge(input int m);
    wait (edge_n >= m - 1);
    @(negedge refclk);
  endtask

  task automatic set_cfg(input int d0, input int p0, input int d1, input int p1,
                         input int d2, input int p2, input logic [2:0] en);
    cfg_div   = {8'(d2), 8'(d1), 8'(d0)};
    cfg_phase = {8'(p2), 8'(p1), 8'(p0)};
    cfg_ch_en = en;
  endtask

  // Bit k of mask i is channel i's expected strobe in RUN cycle k.
  task automatic push_pattern(input int n, input logic [31:0] m0, input logic [31:0] m1,
                              input logic [31:0] m2);
    for (int k = 0; k < n; k++) exp_q.push_back({m2[k], m1[k], m0[k]});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge refclk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(posedge refclk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget && ready !== lvl; i++) @(negedge refclk);
    check(name, 32'(ready), 32'(lvl));
  endtask

  initial begin
    int e, r;
    rst = 1'b1;
    pll_locked = 1'b0;
    cfg_load = 1'b0;
    set_cfg(4, 0, 3, 1, 0, 0, 3'b011);

    after_edge(3);
    rst = 1'b0;
    at_edge(4);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_domain_rst", 32'(domain_rst), 32'd1);
    check("reset_ce", 32'(ce_out), 32'd0);
    check("reset_lost_cnt", 32'(lock_lost_cnt), 32'd0);
    mon_en = 1'b1;

    // Lock acquire with ch0 d=4 p=0 and ch1 d=3 p=1.
    after_edge(9);
    pll_locked = 1'b1;
    push_pattern(12, 32'h888, 32'h492, 32'h0);
    at_edge(28);
    check("acq_ready_early", 32'(ready), 32'd0);
    check("acq_drst_early", 32'(domain_rst), 32'd1);
    at_edge(29);
    check("acq_ready", 32'(ready), 32'd1);
    check("acq_drst", 32'(domain_rst), 32'd0);
    drain(40);

    // Edge ratios: d=0, d=1, d=5 with out-of-range phase 7.
    set_cfg(0, 0, 1, 0, 5, 7, 3'b111);
    pulse_load();
    push_pattern(10, 32'h3FF, 32'h3FF, 32'h210);
    drain(40);

    // Realign with ch0 d 4->2, then live config changes without a load.
    set_cfg(2, 0, 3, 1, 5, 0, 3'b111);
    pulse_load();
    push_pattern(16, 32'hAAAA, 32'h2492, 32'h4210);
    repeat (3) @(posedge refclk);
    #1;
    set_cfg(9, 3, 7, 2, 1, 0, 3'b100);
    drain(40);

    // Sub-cycle glitch between edges never reaches the synchroniser.
    @(posedge refclk);
    #2 pll_locked = 1'b0;
    #3 pll_locked = 1'b1;
    repeat (6) @(negedge refclk);
    check("glitch_ready", 32'(ready), 32'd1);
    check("glitch_lost_cnt", 32'(lock_lost_cnt), 32'd0);

    // Lock loss in RUN, then full requalification with config latched on entry.
    e = edge_n + 2;
    after_edge(e - 1);
    pll_locked = 1'b0;
    set_cfg(4, 0, 3, 1, 0, 0, 3'b011);
    at_edge(e + 2);
    check("loss_ready_hold", 32'(ready), 32'd1);
    at_edge(e + 3);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_drst", 32'(domain_rst), 32'd1);
    check("loss_ce", 32'(ce_out), 32'd0);
    check("loss_cnt", 32'(lock_lost_cnt), 32'd1);
    r = edge_n + 4;
    after_edge(r - 1);
    pll_locked = 1'b1;
    push_pattern(12, 32'h888, 32'h492, 32'h0);
    at_edge(r + 18);
    check("relock_ready_early", 32'(ready), 32'd0);
    at_edge(r + 19);
    check("relock_ready", 32'(ready), 32'd1);
    drain(40);

    // Drop during STABLE restarts qualification without counting as a loss.
    e = edge_n + 2;
    after_edge(e - 1);
    pll_locked = 1'b0;
    at_edge(e + 3);
    check("loss2_cnt", 32'(lock_lost_cnt), 32'd2);
    r = edge_n + 3;
    after_edge(r - 1);
    pll_locked = 1'b1;
    after_edge(r + 7);
    pll_locked = 1'b0;
    after_edge(r + 10);
    pll_locked = 1'b1;
    at_edge(r + 19);
    check("stab_glitch_no_early_ready", 32'(ready), 32'd0);
    at_edge(r + 29);
    check("stab_glitch_ready_early", 32'(ready), 32'd0);
    at_edge(r + 30);
    check("stab_glitch_ready", 32'(ready), 32'd1);
    check("stab_glitch_cnt", 32'(lock_lost_cnt), 32'd2);

    // cfg_load coinciding with locked_s falling: the loss wins.
    set_cfg(2, 0, 3, 1, 5, 0, 3'b111);
    e = edge_n + 2;
    after_edge(e - 1);
    pll_locked = 1'b0;
    after_edge(e + 1);
    cfg_load = 1'b1;
    after_edge(e + 2);
    cfg_load = 1'b0;
    at_edge(e + 3);
    check("collide_ready", 32'(ready), 32'd0);
    check("collide_cnt", 32'(lock_lost_cnt), 32'd3);
    r = edge_n + 3;
    after_edge(r - 1);
    pll_locked = 1'b1;
    push_pattern(12, 32'hAAA, 32'h492, 32'h210);
    at_edge(r + 19);
    check("collide_relock_ready", 32'(ready), 32'd1);
    drain(40);

    // 300 further losses saturate the counter at 255.
    for (int i = 0; i < 300; i++) begin
      @(negedge refclk);
      pll_locked = 1'b0;
      wait_ready(1'b0, 20, "sat_drop");
      check("sat_cnt", 32'(lock_lost_cnt), (i + 4 > 255) ? 32'd255 : 32'(i + 4));
      pll_locked = 1'b1;
      wait_ready(1'b1, 40, "sat_relock");
    end
    check("sat_final", 32'(lock_lost_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
